bytecode_fetch_unit: RTL and testbench
======================================

// Module: bytecode_fetch_unit
// PURPOSE
//  Upstream byte source for the JVM->ARM translator FSM. Walks the JVM bytecode stream
//  held in a word-wide bytecode memory and returns one byte per start/ready handshake.
//  A one-word buffer serves up to four consecutive bytes per memory read.
//  Also provides pc rewind to byte 0 and an end-of-code indication.
// PARAMETERS
//  SIZE           1024  bytecode memory size in bytes (multiple of 4)
//  ADDRESS_WIDTH  10    byte-address width; 2**ADDRESS_WIDTH >= SIZE
// PORTS
//  clk        in   1      sole clock; all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      1-cycle request for next byte; ignored unless idle
//  pc_reset   in   1      synchronous rewind: pc<=0, buffer invalid, abort request
//  code_len   in   AW+1   valid bytecode length in bytes; static while active
//  ready      out  1      1-cycle pulse: next_byte/eoc valid this cycle
//  next_byte  out  8      fetched byte; holds value until next ready
//  eoc        out  1      with ready: pc >= code_len, next_byte = 8'h00
//  pc         out  AW     byte address of the next byte to be returned
//  mem_rd     out  1      bytecode memory read strobe, 1 cycle
//  mem_addr   out  AW-2   word address, valid while mem_rd=1
//  mem_rdata  in   32     read data, valid the cycle after mem_rd (latency 1)
// BEHAVIOUR
//  Reset (rst_n=0, async): state IDLE; ready=0, next_byte=0, eoc=0, pc=0,
//   mem_rd=0, mem_addr=0, buf_valid=0.
//  Byte order: big-endian. pc[1:0]=0 -> word[31:24]; 1 -> [23:16]; 2 -> [15:8]; 3 -> [7:0].
//  FSM states IDLE, FETCH, CAPTURE, DELIVER.
//   IDLE: when start=1:
//    - pc >= code_len -> DELIVER with eoc=1, byte 0x00, no read, pc unchanged.
//    - buf_valid && buf_waddr==pc[AW-1:2] (hit) -> DELIVER.
//    - otherwise (miss) -> FETCH.
//   FETCH: mem_rd=1, mem_addr=pc[AW-1:2]; next state CAPTURE.
//   CAPTURE: buf<=mem_rdata, buf_waddr<=pc[AW-1:2], buf_valid<=1; next state DELIVER.
//   DELIVER: drive the registered outputs for one cycle:
//    - ready=1, next_byte=selected lane;
//    - pc<=pc+1 if eoc=0;
//    - next state IDLE.
//  Latency, counted from the cycle start=1 is sampled in IDLE:
//   - hit or eoc: ready 1 cycle later;
//   - miss: ready 3 cycles later.
//  Only one request may be in flight. start in FETCH, CAPTURE or DELIVER is dropped,
//   with no queueing. The FSM may pulse start again in the cycle after ready.
//  pc_reset has priority over start and over every state:
//   - pc<=0, buf_valid<=0, next state IDLE;
//   - ready/mem_rd deasserted next cycle; an in-flight miss is discarded.
//  pc_reset && start in the same cycle: start is lost.
//  pc wrap: pc+1 wraps modulo 2**AW. It is unreachable when code_len <= SIZE.
//  code_len > SIZE is illegal; behaviour is undefined.
//  mem_rdata is ignored outside CAPTURE.
// STRUCTURE
//  Shared package (jvm_xlat_pkg):
//   - FSM state localparams;
//   - BYTE_LANE_* lane-select constants;
//   - JVM_OP_WIDE = 8'hC4 (used by the consumer FSM).
//  Sub-module: fetch_word_buffer. Holds the 32-bit word, its word address and the valid
//   bit; provides the hit compare and the big-endian lane mux.
//  Top level holds the FSM, pc and output registers.
// TESTING
//  1. Memory word0=32'hB2_00_02_12, code_len=4; four start pulses
//     -> ready at +3, +1, +1, +1 cycles; bytes B2, 00, 02, 12; exactly one mem_rd; pc=4.
//  2. Continue to the fifth start -> ready +1 cycle, eoc=1, next_byte=00, pc stays 4, no mem_rd.
//  3. code_len=8, word1=32'h10_05_C4_15; read bytes 0..4
//     -> second mem_rd with mem_addr=1 on byte 4; next_byte=10.
//  4. pc_reset asserted in CAPTURE of a miss -> no ready; pc=0; the next start misses again
//     (mem_addr=0).
//  5. start held high 4 cycles -> exactly one ready; extra pulses during the miss are ignored.
//  6. rst_n dropped mid-DELIVER -> ready, mem_rd and pc are 0 immediately (async).
//     After release, a start returns byte 0 with miss latency.

Source files
------------

// File: rtl/jvm_xlat_pkg.sv
// Shared definitions for the JVM->ARM translator: fetch FSM states, byte-lane
// selectors and the opcode constants the consumer FSM keys on.
package jvm_xlat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DELIVER = 2'd3
    } fetch_state_t;

    localparam logic [1:0] BYTE_LANE_0 = 2'd0;
    localparam logic [1:0] BYTE_LANE_1 = 2'd1;
    localparam logic [1:0] BYTE_LANE_2 = 2'd2;
    localparam logic [1:0] BYTE_LANE_3 = 2'd3;

    localparam logic [7:0] JVM_OP_WIDE = 8'hC4;

    // Big-endian: lane 0 is the most significant byte of the word.
    function automatic logic [7:0] select_lane(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] result;
        case (lane)
            BYTE_LANE_0: result = word[31:24];
            BYTE_LANE_1: result = word[23:16];
            BYTE_LANE_2: result = word[15:8];
            default:     result = word[7:0];
        endcase
        return result;
    endfunction

endpackage

// File: rtl/fetch_word_buffer.sv
// One-word cache of the bytecode stream: stored word, its word address and a
// valid flag, with the hit compare and the big-endian lane mux.
module fetch_word_buffer
    import jvm_xlat_pkg::*;
#(
    parameter int WADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               load,
    input  logic [31:0]        load_word,
    input  logic [WADDR_W-1:0] load_waddr,
    input  logic [WADDR_W-1:0] lookup_waddr,
    input  logic [1:0]         lane,
    output logic               hit,
    output logic [7:0]         lane_byte
);

    logic [31:0]        word;
    logic [WADDR_W-1:0] waddr;
    logic               valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word  <= '0;
            waddr <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            word  <= load_word;
            waddr <= load_waddr;
            valid <= 1'b1;
        end
    end

    assign hit       = valid && (waddr == lookup_waddr);
    assign lane_byte = select_lane(word, lane);

endmodule

// File: rtl/bytecode_fetch_unit.sv
// Byte-at-a-time fetch front end for the translator FSM: walks the word-wide
// bytecode memory, serving up to four bytes per read from a one-word buffer.
module bytecode_fetch_unit
    import jvm_xlat_pkg::*;
#(
    parameter int SIZE          = 1024,
    parameter int ADDRESS_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     pc_reset,
    input  logic [ADDRESS_WIDTH:0]   code_len,
    output logic                     ready,
    output logic [7:0]               next_byte,
    output logic                     eoc,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic                     mem_rd,
    output logic [ADDRESS_WIDTH-3:0] mem_addr,
    input  logic [31:0]              mem_rdata
);

    localparam int WADDR_W = ADDRESS_WIDTH - 2;
    localparam logic [ADDRESS_WIDTH:0] SIZE_LEN = (ADDRESS_WIDTH + 1)'(SIZE);

    fetch_state_t       state;
    logic [WADDR_W-1:0] pc_waddr;
    logic               at_end;
    logic               buf_hit;
    logic [7:0]         buf_byte;
    logic               buf_load;

    assign pc_waddr = pc[ADDRESS_WIDTH-1:2];
    // Running past the physical memory is treated like end of code.
    assign at_end   = ({1'b0, pc} >= code_len) || ({1'b0, pc} >= SIZE_LEN);
    assign buf_load = (state == ST_CAPTURE) && !pc_reset;

    fetch_word_buffer #(.WADDR_W(WADDR_W)) u_buffer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (pc_reset),
        .load         (buf_load),
        .load_word    (mem_rdata),
        .load_waddr   (pc_waddr),
        .lookup_waddr (pc_waddr),
        .lane         (pc[1:0]),
        .hit          (buf_hit),
        .lane_byte    (buf_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ready     <= 1'b0;
            next_byte <= 8'h00;
            eoc       <= 1'b0;
            pc        <= '0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
        end else if (pc_reset) begin
            state  <= ST_IDLE;
            ready  <= 1'b0;
            eoc    <= 1'b0;
            pc     <= '0;
            mem_rd <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (at_end) begin
                            ready     <= 1'b1;
                            eoc       <= 1'b1;
                            next_byte <= 8'h00;
                            state     <= ST_DELIVER;
                        end else if (buf_hit) begin
                            ready     <= 1'b1;
                            next_byte <= buf_byte;
                            state     <= ST_DELIVER;
                        end else begin
                            mem_rd   <= 1'b1;
                            mem_addr <= pc_waddr;
                            state    <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    mem_rd <= 1'b0;
                    state  <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    // Bypass the buffer so the freshly read word is delivered this pass.
                    ready     <= 1'b1;
                    next_byte <= select_lane(mem_rdata, pc[1:0]);
                    state     <= ST_DELIVER;
                end
                ST_DELIVER: begin
                    ready <= 1'b0;
                    eoc   <= 1'b0;
                    if (!eoc) begin
                        pc <= pc + ADDRESS_WIDTH'(1);
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bytecode_fetch_unit.sv
// Directed and randomized checks of bytecode_fetch_unit against a byte-stream
// reference model with a one-word buffer and fixed hit/miss latencies.
module tb_bytecode_fetch_unit;

    localparam int AW   = 10;
    localparam int SIZE = 1024;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          pc_reset;
    logic [AW:0]   code_len;
    logic          ready;
    logic [7:0]    next_byte;
    logic          eoc;
    logic [AW-1:0] pc;
    logic          mem_rd;
    logic [AW-3:0] mem_addr;
    logic [31:0]   mem_rdata;

    logic [31:0] mem_words [0:SIZE/4-1];
    int          rd_count;
    int          last_addr;

    int n_assert;
    int n_fail;

    int m_pc;
    bit m_bv;
    int m_bw;

    bytecode_fetch_unit #(.SIZE(SIZE), .ADDRESS_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pc_reset  (pc_reset),
        .code_len  (code_len),
        .ready     (ready),
        .next_byte (next_byte),
        .eoc       (eoc),
        .pc        (pc),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory, latency 1; garbage when not reading.
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_rdata <= mem_words[mem_addr];
            rd_count  <= rd_count + 1;
            last_addr <= int'(mem_addr);
        end else begin
            mem_rdata <= 32'hDEAD_BEEF;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input int p);
        logic [31:0] w;
        w = mem_words[p / 4];
        return 8'((w >> (8 * (3 - (p % 4)))) & 32'hFF);
    endfunction

    // Issue one start pulse; return latency, byte, eoc and whether ready was a single-cycle pulse.
    task automatic req(output int lat, output logic [7:0] b, output logic e, output logic ready_after);
        lat = 99;
        b = 8'hxx;
        e = 1'bx;
        start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (ready) begin
                lat = k;
                b = next_byte;
                e = eoc;
                break;
            end
        end
        @(posedge clk);
        #1;
        ready_after = ready;
    endtask

    task automatic model_req(input string tag);
        int exp_lat, exp_rd, rd0, lat, old_pc;
        logic [7:0] exp_b, b;
        logic exp_e, e, ra;
        old_pc = m_pc;
        if (m_pc >= int'(code_len)) begin
            exp_lat = 1; exp_e = 1'b1; exp_b = 8'h00; exp_rd = 0;
        end else begin
            exp_b = byte_at(m_pc);
            exp_e = 1'b0;
            if (m_bv && m_bw == m_pc / 4) begin
                exp_lat = 1; exp_rd = 0;
            end else begin
                exp_lat = 3; exp_rd = 1;
                m_bv = 1'b1;
                m_bw = m_pc / 4;
            end
            m_pc = (m_pc + 1) % SIZE;
        end
        rd0 = rd_count;
        req(lat, b, e, ra);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_byte"}, b, exp_b);
        check({tag, "_eoc"}, e, exp_e);
        check({tag, "_reads"}, rd_count - rd0, exp_rd);
        if (exp_rd == 1) check({tag, "_addr"}, last_addr, old_pc / 4);
        check({tag, "_pc"}, pc, m_pc);
        check({tag, "_pulse"}, ra, 1'b0);
    endtask

    task automatic do_pc_reset();
        pc_reset = 1'b1;
        @(posedge clk);
        #1;
        pc_reset = 1'b0;
        m_pc = 0;
        m_bv = 1'b0;
        check("pc_reset_pc", pc, 0);
    endtask

    initial begin
        int cnt, rd0;
        logic seen;
        n_assert = 0;
        n_fail = 0;
        rd_count = 0;
        last_addr = -1;
        mem_rdata = 32'h0;
        for (int i = 0; i < SIZE / 4; i++) mem_words[i] = 32'h0;
        start = 1'b0;
        pc_reset = 1'b0;
        code_len = '0;
        rst_n = 1'b0;
        m_pc = 0;
        m_bv = 1'b0;
        m_bw = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready, 1'b0);
        check("rst_next_byte", next_byte, 8'h00);
        check("rst_eoc", eoc, 1'b0);
        check("rst_pc", pc, 0);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_mem_addr", mem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single word, four bytes then end of code
        mem_words[0] = 32'hB2_00_02_12;
        code_len = 11'd4;
        rd0 = rd_count;
        for (int i = 0; i < 4; i++) model_req($sformatf("t1_b%0d", i));
        check("t1_total_reads", rd_count - rd0, 1);
        check("t1_pc", pc, 4);
        model_req("t2_eoc");
        model_req("t2_eoc_again");

        // Crossing into the second word
        mem_words[1] = 32'h10_05_C4_15;
        code_len = 11'd8;
        do_pc_reset();
        for (int i = 0; i < 5; i++) model_req($sformatf("t3_b%0d", i));

        // Abort a miss in CAPTURE
        do_pc_reset();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("t4_fetch_rd", mem_rd, 1'b1);
        @(posedge clk);
        #1;
        check("t4_capture_rd", mem_rd, 1'b0);
        pc_reset = 1'b1;
        seen = 1'b0;
        @(posedge clk);
        #1;
        pc_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (ready) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        check("t4_no_ready", seen, 1'b0);
        check("t4_pc", pc, 0);
        m_pc = 0;
        m_bv = 1'b0;
        model_req("t4_remiss");

        // start held for four cycles during a miss
        do_pc_reset();
        rd0 = rd_count;
        cnt = 0;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (ready) cnt++;
        end
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (ready) cnt++;
        end
        check("t5_ready_count", cnt, 1);
        check("t5_reads", rd_count - rd0, 1);
        check("t5_pc", pc, 1);
        m_pc = 1;
        m_bv = 1'b1;
        m_bw = 0;
        model_req("t5_next_hit");

        // Asynchronous reset in the middle of DELIVER
        seen = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (ready) begin
                seen = 1'b1;
                break;
            end
        end
        check("t6_ready_seen", seen, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_ready_async", ready, 1'b0);
        check("t6_mem_rd_async", mem_rd, 1'b0);
        check("t6_pc_async", pc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_pc = 0;
        m_bv = 1'b0;
        model_req("t6_after_reset");

        // Randomized traffic over a random image
        for (int i = 0; i < 32; i++) mem_words[i] = $urandom;
        code_len = 11'($urandom_range(1, 100));
        do_pc_reset();
        for (int it = 0; it < 90; it++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r < 2) begin
                do_pc_reset();
            end else if (r < 4) begin
                code_len = 11'($urandom_range(0, 120));
            end else begin
                model_req($sformatf("rnd%0d", it));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
